// File: rtl/sa_result_writer.sv
// Writes an 8x8 systolic-array result tile back to memory one row per accepted write.
// Build option SA_WB_RELU_EN zeroes every element whose sign bit is set when the tile is captured.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 16
`endif

module sa_result_writer (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [7:0][7:0][`DATA_WIDTH-1:0]         Out,
    input  logic [`ADDR_WIDTH-1:0]                   base_C,
    input  logic [`DIM_WIDTH-1:0]                    dim_col_C,
    input  logic [3:0]                               num_rows,
    input  logic [3:0]                               num_cols,
    output logic                                     write,
    output logic [`ADDR_WIDTH-1:0]                   write_addr,
    output logic [`BANDWIDTH-1:0][`DATA_WIDTH-1:0]   writedata,
    output logic [`BANDWIDTH-1:0]                    write_mask,
    input  logic                                     waitrequest,
    output logic                                     busy,
    output logic                                     done
);

    localparam int DW = `DATA_WIDTH;
    localparam int AW = `ADDR_WIDTH;
    localparam int BW = `BANDWIDTH;

    generate
        if (BW < 8) begin : g_bw_too_small
            $error("sa_result_writer: BANDWIDTH must be at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [7:0][7:0][DW-1:0] tile_reg;
    logic [7:0][7:0][DW-1:0] tile_in;
    logic [AW-1:0]           addr_reg;
    logic [`DIM_WIDTH-1:0]   stride_reg;
    logic [3:0]              rows_reg;
    logic [3:0]              cols_reg;
    logic [3:0]              row_reg;
    logic                    capture;
    logic                    accept;
    logic                    last_row;

    function automatic logic [3:0] clamp8(input logic [3:0] v);
        return (v > 4'd8) ? 4'd8 : v;
    endfunction

    // Tile elements are filtered on the way into the capture register, so both builds share timing.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_row
            for (gj = 0; gj < 8; gj++) begin : g_col
`ifdef SA_WB_RELU_EN
                assign tile_in[gi][gj] = Out[gi][gj][DW-1] ? '0 : Out[gi][gj];
`else
                assign tile_in[gi][gj] = Out[gi][gj];
`endif
            end
        end
    endgenerate

    assign capture  = (state_reg == IDLE) && start;
    assign accept   = (state_reg == WRITE) && !waitrequest;
    assign last_row = (row_reg == (rows_reg - 4'd1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        write      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (clamp8(num_rows) == 4'd0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                write = 1'b1;
                busy  = 1'b1;
                if (!waitrequest && last_row) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The row address is accumulated rather than multiplied; wrap-around gives the modulo for free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tile_reg   <= '0;
            addr_reg   <= '0;
            stride_reg <= '0;
            rows_reg   <= '0;
            cols_reg   <= '0;
            row_reg    <= '0;
        end else if (capture) begin
            tile_reg   <= tile_in;
            addr_reg   <= base_C;
            stride_reg <= dim_col_C;
            rows_reg   <= clamp8(num_rows);
            cols_reg   <= clamp8(num_cols);
            row_reg    <= '0;
        end else if (accept) begin
            row_reg    <= row_reg + 4'd1;
            addr_reg   <= addr_reg + AW'(stride_reg);
        end
    end

    assign write_addr = write ? addr_reg : '0;

    generate
        for (gi = 0; gi < BW; gi++) begin : g_lane
            if (gi < 8) begin : g_live
                assign writedata[gi]  = write ? tile_reg[row_reg[2:0]][gi] : '0;
                assign write_mask[gi] = write && (cols_reg > 4'(gi));
            end else begin : g_pad
                assign writedata[gi]  = '0;
                assign write_mask[gi] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sa_result_writer.sv
// Randomised self-checking bench for sa_result_writer; the expected row stream comes from a
// snapshot of the tile and plain address arithmetic, one row per accepted write.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 16
`endif

module tb_sa_result_writer;

    localparam int DW  = `DATA_WIDTH;
    localparam int AW  = `ADDR_WIDTH;
    localparam int DMW = `DIM_WIDTH;
    localparam int BW  = `BANDWIDTH;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      start;
    logic [7:0][7:0][DW-1:0]   out_tile;
    logic [AW-1:0]             base_C;
    logic [DMW-1:0]            dim_col_C;
    logic [3:0]                num_rows;
    logic [3:0]                num_cols;
    logic                      write;
    logic [AW-1:0]             write_addr;
    logic [BW-1:0][DW-1:0]     writedata;
    logic [BW-1:0]             write_mask;
    logic                      waitrequest;
    logic                      busy;
    logic                      done;

    int checks = 0;
    int errors = 0;

    sa_result_writer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .Out         (out_tile),
        .base_C      (base_C),
        .dim_col_C   (dim_col_C),
        .num_rows    (num_rows),
        .num_cols    (num_cols),
        .write       (write),
        .write_addr  (write_addr),
        .writedata   (writedata),
        .write_mask  (write_mask),
        .waitrequest (waitrequest),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
`ifdef SA_WB_RELU_EN
        return x[DW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    task automatic randomize_tile();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                out_tile[r][c] = DW'($urandom);
    endtask

    // Runs one transfer from the current negedge and checks every cycle until busy falls.
    task automatic do_transfer(input string name, input int nr, input int nc,
                               input logic [AW-1:0] base, input logic [DMW-1:0] stride,
                               input int stall_row, input int stall_len, input bit rand_stall,
                               input bit perturb, input bit start_in_done, input bit rand_tile,
                               output int done_cyc, output int rows_written,
                               output logic [7:0][DW-1:0] row0);
        logic [7:0][7:0][DW-1:0] snap;
        logic [AW-1:0]           ea;
        logic [BW-1:0][DW-1:0]   ed;
        logic [BW-1:0]           em;
        int R, C, exp_r, stalls, stall_left;
        bit finished, after_done, exp_done;

        if (rand_tile) randomize_tile();
        num_rows  = 4'(nr);
        num_cols  = 4'(nc);
        base_C    = base;
        dim_col_C = stride;
        start     = 1'b1;
        snap      = out_tile;
        R = (nr > 8) ? 8 : nr;
        C = (nc > 8) ? 8 : nc;
        exp_r = 0; stalls = 0; stall_left = stall_len; done_cyc = -1; finished = 0;
        row0 = '0;
        @(negedge clock);
        for (int c = 1; c < 200 && !finished; c++) begin
            start = 1'b0;
            if (perturb && (c == 2 || c == 3)) begin
                randomize_tile();
                base_C   = AW'($urandom);
                num_rows = 4'($urandom_range(0, 15));
                start    = (c == 3);
            end
            if (exp_r < R) begin
                waitrequest = 1'b0;
                if (exp_r == stall_row && stall_left > 0) begin
                    waitrequest = 1'b1;
                    stall_left--;
                end else if (rand_stall) begin
                    waitrequest = ($urandom_range(0, 2) == 0);
                end
            end else begin
                waitrequest = 1'($urandom_range(0, 1));
            end
            #1;
            ea = '0; ed = '0; em = '0;
            if (exp_r < R) begin
                ea = base + AW'(exp_r) * AW'(stride);
                for (int j = 0; j < 8; j++) ed[j] = relu(snap[exp_r][j]);
                for (int j = 0; j < C; j++) em[j] = 1'b1;
            end
            checks++;
            if (write !== (exp_r < R)) begin
                errors++;
                $display("FAIL %s write c=%0d: got %b want %b", name, c, write, exp_r < R);
            end
            checks++;
            if (write_addr !== ea) begin
                errors++;
                $display("FAIL %s addr c=%0d row=%0d: got %h want %h", name, c, exp_r, write_addr, ea);
            end
            checks++;
            if (writedata !== ed) begin
                errors++;
                $display("FAIL %s data c=%0d row=%0d: got %h want %h", name, c, exp_r, writedata, ed);
            end
            checks++;
            if (write_mask !== em) begin
                errors++;
                $display("FAIL %s mask c=%0d: got %h want %h", name, c, write_mask, em);
            end
            after_done = (done_cyc >= 0);
            exp_done   = !after_done && (exp_r == R);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL %s done c=%0d: got %b want %b", name, c, done, exp_done);
            end
            checks++;
            if (busy !== !after_done) begin
                errors++;
                $display("FAIL %s busy c=%0d: got %b want %b", name, c, busy, !after_done);
            end
            if (after_done) begin
                finished = 1;
            end else begin
                if (exp_done) begin
                    done_cyc = c;
                    if (start_in_done) start = 1'b1;
                end
                if (exp_r < R) begin
                    if (waitrequest) stalls++;
                    else begin
                        if (exp_r == 0) row0 = ed[7:0];
                        exp_r++;
                    end
                end
                @(negedge clock);
            end
        end
        start = 1'b0;
        waitrequest = 1'b0;
        rows_written = exp_r;
        checks++;
        if (!finished || done_cyc != R + stalls + 1) begin
            errors++;
            $display("FAIL %s completion: got done cycle %0d want %0d (finished=%0d)",
                     name, done_cyc, R + stalls + 1, finished);
        end
        $display("%s: rows=%0d cols=%0d base=%h stride=%0d stalls=%0d done_cycle=%0d",
                 name, nr, nc, base, stride, stalls, done_cyc);
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if ({write, busy, done, write_addr, writedata, write_mask} !== '0) begin
            errors++;
            $display("FAIL %s outputs: got write=%b busy=%b done=%b addr=%h mask=%h want all 0",
                     name, write, busy, done, write_addr, write_mask);
        end
    endtask

    task automatic test_reset();
        #1;
        check_idle_zero("reset_during");
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_idle_zero("reset_held");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_idle_zero("reset_after");
        $display("test_reset: done");
    endtask

    task automatic test_full_tile();
        int dc, rw; logic [7:0][DW-1:0] r0;
        do_transfer("full_tile", 8, 8, AW'(32'h100), DMW'(16), -1, 0, 0, 0, 0, 1, dc, rw, r0);
        checks++;
        if (dc != 9 || rw != 8) begin
            errors++;
            $display("FAIL full_tile latency: got done %0d rows %0d want 9 8", dc, rw);
        end
    endtask

    task automatic test_stall();
        int dc, rw; logic [7:0][DW-1:0] r0;
        do_transfer("stall", 8, 8, AW'(32'h100), DMW'(16), 2, 3, 0, 0, 0, 1, dc, rw, r0);
        checks++;
        if (dc != 12 || rw != 8) begin
            errors++;
            $display("FAIL stall latency: got done %0d rows %0d want 12 8", dc, rw);
        end
    endtask

    task automatic test_partial();
        int dc, rw; logic [7:0][DW-1:0] r0;
        do_transfer("partial", 3, 5, AW'($urandom), DMW'($urandom), -1, 0, 0, 0, 0, 1, dc, rw, r0);
        checks++;
        if (rw != 3 || dc != 4) begin
            errors++;
            $display("FAIL partial count: got rows %0d done %0d want 3 4", rw, dc);
        end
        do_transfer("zero_rows", 0, 8, AW'($urandom), DMW'($urandom), -1, 0, 0, 0, 0, 1, dc, rw, r0);
        checks++;
        if (rw != 0 || dc != 1) begin
            errors++;
            $display("FAIL zero_rows: got rows %0d done %0d want 0 1", rw, dc);
        end
        do_transfer("clamped", 12, 15, AW'($urandom), DMW'($urandom), -1, 0, 0, 0, 0, 1, dc, rw, r0);
        checks++;
        if (rw != 8 || dc != 9) begin
            errors++;
            $display("FAIL clamped: got rows %0d done %0d want 8 9", rw, dc);
        end
    endtask

    task automatic test_capture();
        int dc, rw; logic [7:0][DW-1:0] r0;
        do_transfer("capture", 8, 6, AW'($urandom), DMW'($urandom), -1, 0, 0, 1, 0, 1, dc, rw, r0);
    endtask

    task automatic test_back_to_back();
        int dc, rw; logic [7:0][DW-1:0] r0;
        do_transfer("b2b_first", 2, 8, AW'($urandom), DMW'($urandom), -1, 0, 0, 0, 1, 1, dc, rw, r0);
        do_transfer("b2b_second", 4, 3, AW'($urandom), DMW'($urandom), -1, 0, 0, 0, 0, 1, dc, rw, r0);
    endtask

    task automatic test_random();
        int dc, rw; logic [7:0][DW-1:0] r0;
        for (int i = 0; i < 8; i++) begin
            do_transfer("random", $urandom_range(0, 15), $urandom_range(0, 15), AW'($urandom),
                        DMW'($urandom), -1, 0, 1, 0, 0, 1, dc, rw, r0);
        end
    endtask

    task automatic test_reset_mid();
        int dc, rw; logic [7:0][DW-1:0] r0;
        randomize_tile();
        num_rows = 4'd8; num_cols = 4'd8;
        base_C = AW'($urandom); dim_col_C = DMW'($urandom);
        waitrequest = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_idle_zero("reset_mid_immediate");
        @(posedge clock);
        #1;
        check_idle_zero("reset_mid_held");
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_idle_zero("reset_mid_after");
        end
        $display("reset_mid: aborted transfer at cycle 4");
        do_transfer("after_reset", 8, 8, AW'($urandom), DMW'($urandom), -1, 0, 0, 0, 0, 1, dc, rw, r0);
    endtask

    task automatic test_relu();
        int dc, rw;
        logic [7:0][DW-1:0] r0;
        logic [2:0][DW-1:0] want;
        randomize_tile();
        out_tile[0][0] = DW'(32'hBF800000);
        out_tile[0][1] = DW'(32'h3F800000);
        out_tile[0][2] = DW'(32'h80000000);
`ifdef SA_WB_RELU_EN
        want[0] = DW'(32'h00000000);
        want[1] = DW'(32'h3F800000);
        want[2] = DW'(32'h00000000);
`else
        want[0] = DW'(32'hBF800000);
        want[1] = DW'(32'h3F800000);
        want[2] = DW'(32'h80000000);
`endif
        do_transfer("relu", 1, 3, AW'(32'h40), DMW'(8), -1, 0, 0, 0, 0, 0, dc, rw, r0);
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (r0[j] !== want[j]) begin
                errors++;
                $display("FAIL relu lane%0d: got %h want %h", j, r0[j], want[j]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        waitrequest = 1'b0;
        out_tile = '0;
        base_C = '0;
        dim_col_C = '0;
        num_rows = '0;
        num_cols = '0;
        test_reset();
        test_full_tile();
        test_stall();
        test_partial();
        test_capture();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_relu();
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_result_writer.md
SA_RESULT_WRITER -- requirements
Module: sa_result_writer

Interface
REQ-001 clock  input  1  system clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle request to write back a result tile; honoured only in IDLE.
REQ-004 Out  input  [7:0][7:0][`DATA_WIDTH-1:0]  systolic array result tile, indexed [row][col].
REQ-005 base_C  input  `ADDR_WIDTH  destination address of row 0.
REQ-006 dim_col_C  input  `DIM_WIDTH  row stride in words.
REQ-007 num_rows, num_cols  input  4 each  valid tile extent; values above 8 are clamped to 8.
REQ-008 write  output  1  memory write request.
REQ-009 write_addr  output  `ADDR_WIDTH  row destination address.
REQ-010 writedata  output  [`BANDWIDTH-1:0][`DATA_WIDTH-1:0]  lane j carries column j of the current row; lanes 8 and above are 0.
REQ-011 write_mask  output  `BANDWIDTH  lane j is 1 iff j < clamped num_cols.
REQ-012 waitrequest  input  1  memory stall; a write is accepted on a cycle with write=1 and waitrequest=0.
REQ-013 busy, done  output  1 each  busy is high outside IDLE; done is a one-cycle completion pulse.
REQ-014 `BANDWIDTH SHALL be at least 8; smaller values are a compile-time error.

Function
REQ-015 FSM states and transitions:
- IDLE: on start, go to WRITE (clamped num_rows > 0) or DONE (clamped num_rows = 0).
- WRITE: on the cycle the last row is accepted, go to DONE.
- DONE: go to IDLE after one cycle.
REQ-016 Capture: the start cycle in IDLE captures Out, base_C, dim_col_C, num_rows and num_cols. Input changes after that cycle SHALL NOT affect the transfer, so the array may be reset immediately.
REQ-017 In WRITE, write=1 continuously. write_addr = base_C + r*dim_col_C, taken modulo 2^`ADDR_WIDTH, where r is the current row index starting at 0.
REQ-018 r SHALL advance only on acceptance (write=1 and waitrequest=0). While stalled, write_addr, writedata and write_mask SHALL hold stable.
REQ-019 Rows SHALL be written in ascending order, exactly once each, with no gap cycles between them.
REQ-020 Latency, waitrequest always 0: start at cycle 0, rows written in cycles 1..R, done=1 in cycle R+1, busy low again at cycle R+2.
REQ-021 With num_rows=0: done in cycle 1 and no write.
REQ-022 start outside IDLE SHALL be ignored. start in the DONE cycle is ignored; a new start is accepted in IDLE from the following cycle.
REQ-023 When write=0: write_addr, writedata and write_mask SHALL be 0.
REQ-024 done=1 only in DONE; busy=1 in WRITE and DONE.

Reset
REQ-025 Asynchronous reset SHALL force IDLE and clear the captured registers and row index.
REQ-026 During and after reset: write, done, busy, write_addr, writedata and write_mask are all 0.
REQ-027 Reset mid-transfer SHALL abort the transfer immediately with no done pulse. The next start begins fresh from row 0.

Configuration
REQ-028 Macro SA_WB_RELU_EN.
- Defined: each captured element whose sign bit [`DATA_WIDTH-1] is 1 SHALL be written as all zeros (ReLU on the IEEE float encoding), including -0.
- Undefined: elements are written bit-exact.
- Latency is identical in both builds.

Verification
REQ-029 Full tile: num_rows=8, num_cols=8, base_C=0x100, dim_col_C=16, no stall -> addresses 0x100, 0x110, …, 0x170 in cycles 1-8; mask=0xFF; done in cycle 9.
REQ-030 Stall: waitrequest high for 3 cycles on row 2 -> row 2 address and data held stable, 3 extra cycles, done in cycle 12, no row duplicated or skipped.
REQ-031 Partial and clamped tile: num_rows=3, num_cols=5 -> 3 writes, mask=0x1F. Separately, num_rows=0 -> no writes, done in cycle 1. Separately, num_rows=12 -> 8 writes.
REQ-032 Capture isolation and ignored start: Out, base_C and num_rows changed, and start pulsed, during WRITE -> written data and addresses match the start-cycle snapshot, and exactly one done pulse.
REQ-033 Reset at cycle 4 of an 8-row transfer -> outputs 0 immediately, no done pulse. A following start writes rows 0..7 correctly.
REQ-034 RELU build: Out[0][0]=0xBF800000, Out[0][1]=0x3F800000, Out[0][2]=0x80000000 -> written 0x00000000, 0x3F800000, 0x00000000. Non-RELU build -> written unchanged.
